// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: runs one load/store at a time on a req/ack data bus,
// holds EX/MEM while the access is in flight, steers store lanes and extends loads.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        rset,
  input  logic        valid_in,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        dreq,
  output logic        dwe,
  output logic [31:0] daddr,
  output logic [3:0]  dbe,
  output logic [31:0] dwdata,
  input  logic        dack,
  input  logic [31:0] drdata,
  output logic        pipe_en,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        addr_err_load,
  output logic        addr_err_store,
  output logic [31:0] badvaddr
);

  localparam int unsigned DW  = 32;
  localparam int unsigned BEW = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;

  logic [1:0]     state_q, state_d;
  logic           dreq_q, dreq_d;
  logic           dwe_q, dwe_d;
  logic [DW-1:0]  daddr_q, daddr_d;
  logic [BEW-1:0] dbe_q, dbe_d;
  logic [DW-1:0]  dwdata_q, dwdata_d;
  logic [DW-1:0]  load_data_q, load_data_d;
  logic           load_valid_q, load_valid_d;
  logic           err_load_q, err_load_d;
  logic           err_store_q, err_store_d;
  logic [DW-1:0]  badvaddr_q, badvaddr_d;

  // Attributes of the in-flight access, needed to format the returning read data
  logic           op_read_q, op_read_d;
  logic [1:0]     op_size_q, op_size_d;
  logic [1:0]     op_lo_q, op_lo_d;
  logic           op_sext_q, op_sext_d;
  logic           flushed_q, flushed_d;

  logic           mem_op_c;
  logic           misaligned_c;
  logic           pipe_en_c;
  logic [BEW-1:0] st_be_c;
  logic [DW-1:0]  st_data_c;
  logic [7:0]     lane_byte_c;
  logic [15:0]    lane_half_c;
  logic [DW-1:0]  ld_ext_c;

  assign mem_op_c     = valid_in & (mem_read | mem_write) & ~flush;
  assign misaligned_c = ((size == SZ_HALF) & addr[0]) | (size[1] & (addr[1:0] != 2'b00));

  // Store lane steering; size encoding 3 falls through to word
  always_comb begin
    st_be_c   = 4'b1111;
    st_data_c = wdata;
    case (size)
      SZ_BYTE: begin
        st_be_c   = 4'b0001 << addr[1:0];
        st_data_c = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        st_be_c   = addr[1] ? 4'b1100 : 4'b0011;
        st_data_c = {2{wdata[15:0]}};
      end
      default: begin
        st_be_c   = 4'b1111;
        st_data_c = wdata;
      end
    endcase
  end

  // Load lane extraction and extension from the latched access attributes
  always_comb begin
    lane_byte_c = drdata[7:0];
    case (op_lo_q)
      2'd0:    lane_byte_c = drdata[7:0];
      2'd1:    lane_byte_c = drdata[15:8];
      2'd2:    lane_byte_c = drdata[23:16];
      default: lane_byte_c = drdata[31:24];
    endcase
    lane_half_c = op_lo_q[1] ? drdata[31:16] : drdata[15:0];
    case (op_size_q)
      SZ_BYTE: ld_ext_c = {{24{op_sext_q & lane_byte_c[7]}}, lane_byte_c};
      SZ_HALF: ld_ext_c = {{16{op_sext_q & lane_half_c[15]}}, lane_half_c};
      default: ld_ext_c = drdata;
    endcase
  end

  // Next-state and output decode
  always_comb begin
    state_d      = state_q;
    dreq_d       = dreq_q;
    dwe_d        = dwe_q;
    daddr_d      = daddr_q;
    dbe_d        = dbe_q;
    dwdata_d     = dwdata_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    err_load_d   = 1'b0;
    err_store_d  = 1'b0;
    badvaddr_d   = badvaddr_q;
    op_read_d    = op_read_q;
    op_size_d    = op_size_q;
    op_lo_d      = op_lo_q;
    op_sext_d    = op_sext_q;
    flushed_d    = flushed_q;
    pipe_en_c    = 1'b1;

    case (state_q)
      IDLE: begin
        if (mem_op_c) begin
          if (misaligned_c) begin
            err_load_d  = mem_read;
            err_store_d = mem_write;
            badvaddr_d  = addr;
          end else begin
            pipe_en_c = 1'b0;
            state_d   = BUSY;
            dreq_d    = 1'b1;
            dwe_d     = mem_write;
            daddr_d   = {addr[31:2], 2'b00};
            dbe_d     = mem_write ? st_be_c : 4'b0000;
            dwdata_d  = mem_write ? st_data_c : 32'h0;
            op_read_d = mem_read;
            op_size_d = size;
            op_lo_d   = addr[1:0];
            op_sext_d = sign_ext;
            flushed_d = 1'b0;
          end
        end
      end
      BUSY: begin
        // A flush cannot cancel the bus cycle; it only suppresses the load result
        pipe_en_c = 1'b0;
        flushed_d = flushed_q | flush;
        if (dack) begin
          dreq_d       = 1'b0;
          dwe_d        = 1'b0;
          dbe_d        = 4'b0000;
          load_data_d  = ld_ext_c;
          load_valid_d = op_read_q & ~(flushed_q | flush);
          state_d      = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rset) begin
    if (!rset) begin
      state_q      <= IDLE;
      dreq_q       <= 1'b0;
      dwe_q        <= 1'b0;
      daddr_q      <= '0;
      dbe_q        <= '0;
      dwdata_q     <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      err_load_q   <= 1'b0;
      err_store_q  <= 1'b0;
      badvaddr_q   <= '0;
      op_read_q    <= 1'b0;
      op_size_q    <= 2'b00;
      op_lo_q      <= 2'b00;
      op_sext_q    <= 1'b0;
      flushed_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      dreq_q       <= dreq_d;
      dwe_q        <= dwe_d;
      daddr_q      <= daddr_d;
      dbe_q        <= dbe_d;
      dwdata_q     <= dwdata_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      err_load_q   <= err_load_d;
      err_store_q  <= err_store_d;
      badvaddr_q   <= badvaddr_d;
      op_read_q    <= op_read_d;
      op_size_q    <= op_size_d;
      op_lo_q      <= op_lo_d;
      op_sext_q    <= op_sext_d;
      flushed_q    <= flushed_d;
    end
  end

  // The hold input must stay released while the block itself is held in reset
  assign pipe_en        = pipe_en_c | ~rset;
  assign dreq           = dreq_q;
  assign dwe            = dwe_q;
  assign daddr          = daddr_q;
  assign dbe            = dbe_q;
  assign dwdata         = dwdata_q;
  assign load_data      = load_data_q;
  assign load_valid     = load_valid_q;
  assign addr_err_load  = err_load_q;
  assign addr_err_store = err_store_q;
  assign badvaddr       = badvaddr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus randomized accesses
// checked against a transaction-level model of lane steering, extension and timing.
module tb_mem_access_ctrl;

  logic        clk;
  logic        rset;
  logic        valid_in;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        flush;
  logic        dreq;
  logic        dwe;
  logic [31:0] daddr;
  logic [3:0]  dbe;
  logic [31:0] dwdata;
  logic        dack;
  logic [31:0] drdata;
  logic        pipe_en;
  logic [31:0] load_data;
  logic        load_valid;
  logic        addr_err_load;
  logic        addr_err_store;
  logic [31:0] badvaddr;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_bad = 32'h0;

  mem_access_ctrl dut (
    .clk(clk), .rset(rset), .valid_in(valid_in), .mem_read(mem_read),
    .mem_write(mem_write), .size(size), .sign_ext(sign_ext), .addr(addr),
    .wdata(wdata), .flush(flush), .dreq(dreq), .dwe(dwe), .daddr(daddr),
    .dbe(dbe), .dwdata(dwdata), .dack(dack), .drdata(drdata), .pipe_en(pipe_en),
    .load_data(load_data), .load_valid(load_valid), .addr_err_load(addr_err_load),
    .addr_err_store(addr_err_store), .badvaddr(badvaddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int unsigned m_nb(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit m_mis(input logic [1:0] sz, input logic [31:0] a);
    return (a % m_nb(sz)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    logic [3:0] full;
    int unsigned off;
    off  = a % 4;
    full = (m_nb(sz) == 1) ? 4'h1 : (m_nb(sz) == 2) ? 4'h3 : 4'hF;
    return full << off;
  endfunction

  function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] wd);
    if (m_nb(sz) == 1) return (wd & 32'hFF) * 32'h01010101;
    if (m_nb(sz) == 2) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] m_ld(input logic [1:0] sz, input bit sx,
                                       input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] mask;
    logic [31:0] v;
    int unsigned off;
    if (m_nb(sz) == 4) return rd;
    off  = a % 4;
    mask = (m_nb(sz) == 1) ? 32'hFF : 32'hFFFF;
    v    = (rd >> (8 * off)) & mask;
    if (sx && (v > (mask >> 1))) v = v - mask - 32'd1;
    return v;
  endfunction

  // ---------------- scenario drivers ----------------
  task automatic run_access(input bit rd, input logic [1:0] sz, input bit sx,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rdd, input int k, input int fl_cyc,
                            output logic [31:0] o_load, output logic [3:0] o_be,
                            output logic [31:0] o_wd, output int o_pe_low);
    logic [3:0]  ebe;
    logic [31:0] ewd;
    logic [31:0] ea;
    bit          elv;
    int          pe_low;
    ebe = rd ? 4'b0000 : m_be(sz, a);
    ewd = m_wd(sz, wd);
    ea  = a & 32'hFFFF_FFFC;
    elv = rd && !(fl_cyc >= 1 && fl_cyc <= k);
    o_be = 4'h0;
    o_wd = 32'h0;

    @(posedge clk); #1;
    valid_in = 1'b1; mem_read = rd; mem_write = !rd; size = sz; sign_ext = sx;
    addr = a; wdata = wd; flush = 1'b0; dack = 1'($urandom % 2); drdata = $urandom;
    @(negedge clk);
    pe_low = pipe_en ? 0 : 1;
    n_cmp++;
    if ({dreq, load_valid, addr_err_load, addr_err_store} !== 4'b0000) begin
      n_err++;
      $display("FAIL issue_cycle: got %b want 0000 (dreq,lv,errL,errS) addr=%h", {dreq, load_valid, addr_err_load, addr_err_store}, a);
    end

    for (int c = 1; c <= k; c++) begin
      @(posedge clk); #1;
      dack   = (c == k);
      drdata = (c == k) ? rdd : $urandom;
      flush  = (c == fl_cyc);
      @(negedge clk);
      if (!pipe_en) pe_low++;
      n_cmp++;
      if ({dreq, dwe, dbe, daddr} !== {1'b1, !rd, ebe, ea}) begin
        n_err++;
        $display("FAIL busy_bus c=%0d: got %h want %h (dreq,dwe,dbe,daddr)", c, {dreq, dwe, dbe, daddr}, {1'b1, !rd, ebe, ea});
      end
      if (!rd) begin
        n_cmp++;
        if (dwdata !== ewd) begin
          n_err++;
          $display("FAIL busy_dwdata c=%0d: got %h want %h", c, dwdata, ewd);
        end
      end
      o_be = dbe;
      o_wd = dwdata;
    end

    @(posedge clk); #1;
    dack = 1'($urandom % 2); flush = 1'b0; drdata = $urandom;
    @(negedge clk);
    if (!pipe_en) pe_low++;
    n_cmp++;
    if ({dreq, dwe, dbe, load_valid} !== {1'b0, 1'b0, 4'b0000, elv}) begin
      n_err++;
      $display("FAIL resp_state: got %b want %b (dreq,dwe,dbe,lv)", {dreq, dwe, dbe, load_valid}, {1'b0, 1'b0, 4'b0000, elv});
    end
    if (rd) begin
      n_cmp++;
      if (load_data !== m_ld(sz, sx, a, rdd)) begin
        n_err++;
        $display("FAIL load_data: got %h want %h (addr=%h sz=%0d sx=%0d rd=%h)", load_data, m_ld(sz, sx, a, rdd), a, sz, sx, rdd);
      end
    end
    n_cmp++;
    if (pe_low !== k + 1) begin
      n_err++;
      $display("FAIL pipe_en_low: got %0d want %0d cycles", pe_low, k + 1);
    end
    o_load   = load_data;
    o_pe_low = pe_low;
  endtask

  task automatic run_misaligned(input bit rd, input logic [1:0] sz, input logic [31:0] a);
    @(posedge clk); #1;
    valid_in = 1'b1; mem_read = rd; mem_write = !rd; size = sz; sign_ext = 1'b0;
    addr = a; wdata = $urandom; flush = 1'b0; dack = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({pipe_en, dreq} !== 2'b10) begin
      n_err++;
      $display("FAIL mis_issue: got %b want 10 (pipe_en,dreq) addr=%h", {pipe_en, dreq}, a);
    end
    @(posedge clk); #1;
    valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    exp_bad = a;
    n_cmp++;
    if ({addr_err_load, addr_err_store, dreq, pipe_en} !== {rd, !rd, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL mis_pulse: got %b want %b (errL,errS,dreq,pe)", {addr_err_load, addr_err_store, dreq, pipe_en}, {rd, !rd, 1'b0, 1'b1});
    end
    n_cmp++;
    if (badvaddr !== exp_bad) begin
      n_err++;
      $display("FAIL mis_badvaddr: got %h want %h", badvaddr, exp_bad);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({addr_err_load, addr_err_store, badvaddr} !== {2'b00, exp_bad}) begin
      n_err++;
      $display("FAIL mis_after: got %h want %h (errL,errS,badvaddr)", {addr_err_load, addr_err_store, badvaddr}, {2'b00, exp_bad});
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rset = 1'b0; valid_in = 1'b1; mem_read = 1'b1; mem_write = 1'b0; size = 2'd2;
    sign_ext = 1'b0; addr = 32'h0000_0100; wdata = 32'h0; flush = 1'b0;
    dack = 1'b0; drdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({dreq, dwe, dbe, daddr, dwdata, load_data, load_valid, addr_err_load,
         addr_err_store, badvaddr, pipe_en} !== {137'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want %h", {dreq, dwe, dbe, daddr, dwdata, load_data, load_valid, addr_err_load, addr_err_store, badvaddr, pipe_en}, {137'b0, 1'b1});
    end
    @(posedge clk); #1;
    rset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({pipe_en, dreq} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_release_issue: got %b want 00 (pipe_en,dreq)", {pipe_en, dreq});
    end
    @(posedge clk); #1;
    dack = 1'b1; drdata = 32'hCAFE_F00D;
    @(negedge clk);
    n_cmp++;
    if ({dreq, dwe, daddr} !== {1'b1, 1'b0, 32'h0000_0100}) begin
      n_err++;
      $display("FAIL reset_first_req: got %h want %h", {dreq, dwe, daddr}, {1'b1, 1'b0, 32'h0000_0100});
    end
    @(posedge clk); #1;
    dack = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({load_valid, load_data, pipe_en} !== {1'b1, 32'hCAFE_F00D, 1'b1}) begin
      n_err++;
      $display("FAIL reset_first_resp: got %h want %h", {load_valid, load_data, pipe_en}, {1'b1, 32'hCAFE_F00D, 1'b1});
    end
    @(posedge clk); #1;
    valid_in = 1'b0; mem_read = 1'b0;
  endtask

  task automatic test_lb;
    logic [31:0] ld, wd;
    logic [3:0]  be;
    int          pe;
    run_access(1'b1, 2'd0, 1'b1, 32'h0000_1003, 32'h0, 32'h805A_A53C, 1, 0, ld, be, wd, pe);
    n_cmp++;
    if ({ld, be} !== {32'hFFFF_FF80, 4'b0000}) begin
      n_err++;
      $display("FAIL lb_directed: got %h want %h (load,dbe)", {ld, be}, {32'hFFFF_FF80, 4'b0000});
    end
    n_cmp++;
    if (pe !== 2) begin
      n_err++;
      $display("FAIL lb_pipe_en: got %0d want 2 cycles low", pe);
    end
  endtask

  task automatic test_sh_slow;
    logic [31:0] ld, wd;
    logic [3:0]  be;
    int          pe;
    run_access(1'b0, 2'd1, 1'b0, 32'h0000_2002, 32'h0000_BEEF, $urandom, 4, 0, ld, be, wd, pe);
    n_cmp++;
    if ({wd, be} !== {32'hBEEF_BEEF, 4'b1100}) begin
      n_err++;
      $display("FAIL sh_directed: got %h want %h (dwdata,dbe)", {wd, be}, {32'hBEEF_BEEF, 4'b1100});
    end
    n_cmp++;
    if (pe !== 5) begin
      n_err++;
      $display("FAIL sh_pipe_en: got %0d want 5 cycles low", pe);
    end
  endtask

  task automatic test_misaligned;
    run_misaligned(1'b1, 2'd2, 32'h0000_3001);
    run_misaligned(1'b0, 2'd2, 32'h0000_3002);
    run_misaligned(1'b1, 2'd1, 32'h0000_3005);
  endtask

  task automatic test_flush_busy;
    logic [31:0] ld, wd;
    logic [3:0]  be;
    int          pe;
    run_access(1'b1, 2'd2, 1'b0, 32'h0000_5000, 32'h0, 32'hDEAD_BEEF, 2, 1, ld, be, wd, pe);
    run_access(1'b1, 2'd1, 1'b0, 32'h0000_4002, 32'h0, 32'h1234_5678, 1, 0, ld, be, wd, pe);
    n_cmp++;
    if (ld !== 32'h0000_1234) begin
      n_err++;
      $display("FAIL lh_after_flush: got %h want 00001234", ld);
    end
  endtask

  // Non-memory instructions and flushed memory ops must never stall or fault
  task automatic test_no_op;
    bit ok;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      valid_in = 1'b1; addr = $urandom | 32'h1; size = 2'(1 + $urandom % 3);
      dack = 1'($urandom % 2); drdata = $urandom;
      if (i % 2 == 0) begin
        mem_read = 1'b0; mem_write = 1'b0; flush = 1'($urandom % 2);
      end else begin
        mem_read = 1'($urandom % 2); mem_write = !mem_read; flush = 1'b1;
      end
      @(negedge clk);
      ok = (pipe_en === 1'b1) && (dreq === 1'b0) && (addr_err_load === 1'b0) &&
           (addr_err_store === 1'b0) && (badvaddr === exp_bad);
      n_cmp++;
      if (!ok) begin
        n_err++;
        $display("FAIL no_op i=%0d: got pe=%b dreq=%b errL=%b errS=%b bad=%h want 1 0 0 0 %h", i, pipe_en, dreq, addr_err_load, addr_err_store, badvaddr, exp_bad);
      end
    end
    @(posedge clk); #1;
    valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0; flush = 1'b0; dack = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [31:0] ld, wd;
    logic [3:0]  be;
    int          pe;
    run_access(1'b0, 2'd2, 1'b0, 32'h0000_6000, 32'h0102_0304, $urandom, 1, 0, ld, be, wd, pe);
    run_access(1'b1, 2'd0, 1'b0, 32'h0000_6001, 32'h0, 32'hAABB_CCDD, 1, 0, ld, be, wd, pe);
    n_cmp++;
    if (ld !== 32'h0000_00CC) begin
      n_err++;
      $display("FAIL b2b_lbu: got %h want 000000CC", ld);
    end
    run_access(1'b0, 2'd0, 1'b0, 32'h0000_6003, 32'h0000_00A7, $urandom, 2, 0, ld, be, wd, pe);
    n_cmp++;
    if ({wd, be} !== {32'hA7A7_A7A7, 4'b1000}) begin
      n_err++;
      $display("FAIL b2b_sb: got %h want %h (dwdata,dbe)", {wd, be}, {32'hA7A7_A7A7, 4'b1000});
    end
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    valid_in = 1'b1; mem_read = 1'b0; mem_write = 1'b1; size = 2'd2;
    addr = 32'h0000_7000; wdata = $urandom; flush = 1'b0; dack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rset = 1'b0;
    #1;
    exp_bad = 32'h0;
    n_cmp++;
    if ({dreq, dwe, pipe_en} !== 3'b001) begin
      n_err++;
      $display("FAIL reset_mid: got %b want 001 (dreq,dwe,pipe_en)", {dreq, dwe, pipe_en});
    end
    @(posedge clk); #1;
    valid_in = 1'b0; mem_write = 1'b0;
    rset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({dreq, pipe_en} !== 2'b01) begin
      n_err++;
      $display("FAIL reset_mid_idle: got %b want 01 (dreq,pipe_en)", {dreq, pipe_en});
    end
  endtask

  task automatic test_random;
    logic [31:0] ld, wd, a;
    logic [3:0]  be;
    logic [1:0]  sz;
    bit          rd;
    int          pe, k, fl;
    for (int i = 0; i < 80; i++) begin
      rd = 1'($urandom % 2);
      sz = 2'($urandom % 4);
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a - (a % m_nb(sz));
      if (m_mis(sz, a)) begin
        run_misaligned(rd, sz, a);
      end else begin
        k  = $urandom_range(1, 4);
        fl = ($urandom_range(0, 2) == 0) ? $urandom_range(1, k) : 0;
        run_access(rd, sz, 1'($urandom % 2), a, $urandom, $urandom, k, fl, ld, be, wd, pe);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lb();
    test_sh_slow();
    test_misaligned();
    test_flush_busy();
    test_no_op();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage access controller that consumes the EX/MEM pipeline register outputs and runs each load/store on a single-outstanding request/acknowledge data bus. It drives the register's hold input, so the EX/MEM contents stay frozen while an access is in flight. It also handles byte/halfword lane steering and load extension, and flags misaligned addresses for the CP0 exception logic.

## Interface
Parameters:
- none. Bus and data widths are fixed at 32 bits.

Ports:
- clk  in  1  single clock, rising edge.
- rset  in  1  reset, asynchronous, active-low.
- valid_in  in  1  EX/MEM holds a live instruction.
- mem_read  in  1  instruction is a load.
- mem_write  in  1  instruction is a store. Never asserted together with mem_read.
- size  in  2  access size: 0 byte, 1 halfword, 2 word. Encoding 3 is treated as word.
- sign_ext  in  1  sign-extend byte/halfword loads (LB/LH); 0 means zero-extend.
- addr  in  32  effective address (ALU result).
- wdata  in  32  store data (rs2 value), right-aligned.
- flush  in  1  exception/eret flush of the current MEM instruction.
- dreq  out  1  bus request.
- dwe  out  1  write enable, meaningful while dreq=1.
- daddr  out  32  word-aligned address: {addr[31:2],2'b00}.
- dbe  out  4  byte enables.
- dwdata  out  32  lane-steered store data.
- dack  in  1  bus acknowledge: single-cycle pulse, write completion or read data valid.
- drdata  in  32  read data, valid when dack=1.
- pipe_en  out  1  drives the EX/MEM hold input. 1 means load new contents, 0 means hold.
- load_data  out  32  extended load result.
- load_valid  out  1  load_data valid for one cycle.
- addr_err_load  out  1  AdEL pulse.
- addr_err_store  out  1  AdES pulse.
- badvaddr  out  32  faulting address, held until the next error.

## Operation
- States:
  - IDLE: no access in flight.
  - BUSY: request issued, waiting for dack.
  - RESP: data or completion captured.
- Reset: state=IDLE. dreq, dwe, dbe, dwdata, daddr, load_data, load_valid, addr_err_* and badvaddr are all 0.
- mem_op = valid_in & (mem_read | mem_write) & ~flush.
- Misalignment:
  - halfword with addr[0]=1;
  - word with addr[1:0]≠0.
- IDLE, mem_op and aligned:
  - pipe_en=0.
  - Next state BUSY.
  - Register dreq=1, dwe=mem_write, daddr, dbe, dwdata.
- IDLE, mem_op and misaligned:
  - No request. pipe_en=1.
  - Next cycle: pulse addr_err_load (for a read) or addr_err_store (for a write), and badvaddr=addr.
- IDLE, otherwise: pipe_en=1.
- BUSY:
  - pipe_en=0.
  - On dack: clear dreq/dwe/dbe, capture the extended drdata into load_data, and go to RESP.
  - load_valid=1 in RESP only if the access was a read and no flush occurred during BUSY.
- RESP: pipe_en=1, next state IDLE unconditionally. The same instruction is never reissued.
- Store steering:
  - byte: dwdata={4{wdata[7:0]}}, dbe=4'b0001<<addr[1:0].
  - half: dwdata={2{wdata[15:0]}}, dbe=addr[1]?4'b1100:4'b0011.
  - word: dwdata=wdata, dbe=4'b1111.
- Load extraction:
  - byte: drdata[8*addr[1:0]+:8].
  - half: drdata[16*addr[1]+:16].
  - Extend to 32 bits per sign_ext. Word loads are passed through.
- Flush:
  - In IDLE it suppresses issue and errors.
  - In BUSY the bus transaction is not cancelled: the block waits for dack, then load_valid stays 0. A store cannot be revoked once issued.
- dack outside BUSY is ignored.
- Reset asserted mid-access returns to IDLE immediately with dreq=0. The bus is expected to be reset by the same rset.

## Timing
- Access issued in cycle T (IDLE decision). dreq is high from T+1 and held with stable daddr/dbe/dwdata/dwe until the cycle in which dack=1.
- Minimum latency: dack at T+1, RESP at T+2.
  - load_data/load_valid valid at T+2.
  - pipe_en=1 at T+2, so EX/MEM advances at the end of T+2.
  - Result: 3 cycles per memory instruction.
- With dack at T+k, RESP occurs at T+k+1.
- dreq falls in the cycle after dack.
- Non-memory instructions: pipe_en=1 continuously, zero added cycles.
- Error outputs are one-cycle pulses at T+1. badvaddr updates at T+1.

## Test plan
- Reset: hold rset=0 with mem_read=1 → all outputs 0 except pipe_en=1. Release rset → first access is issued on the next edge.
- LB, addr=0x1003, sign_ext=1, dack one cycle after dreq with drdata=0x80xxxxxx:
  - daddr=0x1000, dbe=0000 (read), load_data=0xFFFFFF80, load_valid at T+2;
  - pipe_en low exactly 2 cycles.
- SH, addr=0x2002, wdata=0x0000BEEF, dack delayed 4 cycles → dwdata=0xBEEFBEEF, dbe=1100, dwe=1, inputs stable for all 4 cycles, pipe_en low 5 cycles.
- LW addr=0x3001 → no dreq, addr_err_load pulse at T+1, badvaddr=0x3001, pipe_en never low.
- SW addr=0x3002 → addr_err_store pulse, badvaddr=0x3002.
- LW with flush asserted in BUSY, dack 2 cycles later → dreq held until dack, load_valid stays 0, FSM returns to IDLE. A following LH at 0x4002 with drdata=0x12345678 and sign_ext=0 → load_data=0x00001234.
